// File: rtl/pipeline_register_1_fetch.sv
// Fetch stage: owns the PC, drives a 1-cycle-latency instruction memory and registers the
// fetched instruction and its PC for decode. A one-entry hold buffer covers the stall case.
module pipeline_register_1_fetch #(
   parameter int unsigned      WIDTH    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_instruction,
   output logic [WIDTH-1:0] out_pc,
   output logic [WIDTH-1:0] out_pc_next
);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic             inflight_valid_q, inflight_valid_d;
   logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
   logic             hold_valid_q, hold_valid_d;
   logic [WIDTH-1:0] hold_instr_q, hold_instr_d;
   logic [WIDTH-1:0] hold_pc_q, hold_pc_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_instr_q, out_instr_d;
   logic [WIDTH-1:0] out_pc_q, out_pc_d;
   logic [WIDTH-1:0] out_pc_next_q, out_pc_next_d;

   assign imem_req        = !reset && !stall && !redirect_valid;
   assign imem_addr       = pc_q;
   assign out_valid       = out_valid_q;
   assign out_instruction = out_instr_q;
   assign out_pc          = out_pc_q;
   assign out_pc_next     = out_pc_next_q;

   always_comb begin
      pc_d             = pc_q;
      inflight_valid_d = inflight_valid_q;
      inflight_pc_d    = inflight_pc_q;
      hold_valid_d     = hold_valid_q;
      hold_instr_d     = hold_instr_q;
      hold_pc_d        = hold_pc_q;
      out_valid_d      = out_valid_q;
      out_instr_d      = out_instr_q;
      out_pc_d         = out_pc_q;
      out_pc_next_d    = out_pc_next_q;

      if (redirect_valid) begin
         // Squash everything younger than the branch; stall only delays the refetch.
         pc_d             = redirect_pc;
         inflight_valid_d = 1'b0;
         hold_valid_d     = 1'b0;
         out_valid_d      = 1'b0;
      end else if (stall) begin
         // The memory returns data regardless of stall, so park it until release.
         if (inflight_valid_q) begin
            hold_valid_d     = 1'b1;
            hold_instr_d     = imem_rdata;
            hold_pc_d        = inflight_pc_q;
            inflight_valid_d = 1'b0;
         end
      end else begin
         pc_d             = pc_q + WIDTH'(1);
         inflight_valid_d = 1'b1;
         inflight_pc_d    = pc_q;
         if (hold_valid_q) begin
            hold_valid_d = 1'b0;
            out_valid_d  = 1'b1;
            out_instr_d  = hold_instr_q;
            out_pc_d     = hold_pc_q;
         end else begin
            out_valid_d  = inflight_valid_q;
            out_instr_d  = imem_rdata;
            out_pc_d     = inflight_pc_q;
         end
         out_pc_next_d = out_pc_d + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q             <= RESET_PC;
         inflight_valid_q <= 1'b0;
         hold_valid_q     <= 1'b0;
         out_valid_q      <= 1'b0;
         out_instr_q      <= '0;
         out_pc_q         <= '0;
         out_pc_next_q    <= '0;
      end else begin
         pc_q             <= pc_d;
         inflight_valid_q <= inflight_valid_d;
         inflight_pc_q    <= inflight_pc_d;
         hold_valid_q     <= hold_valid_d;
         hold_instr_q     <= hold_instr_d;
         hold_pc_q        <= hold_pc_d;
         out_valid_q      <= out_valid_d;
         out_instr_q      <= out_instr_d;
         out_pc_q         <= out_pc_d;
         out_pc_next_q    <= out_pc_next_d;
      end
   end

endmodule

// File: tb/tb_pipeline_register_1_fetch.sv
// Bench for the fetch stage: two instances (RESET_PC 0 and 0xFFFE) share stimulus and are
// compared against a queue model of fetched-but-undelivered addresses.
module tb_pipeline_register_1_fetch;

   localparam logic [15:0] RPC [2] = '{16'h0000, 16'hFFFE};

   logic        clk = 1'b0;
   logic        reset, stall, redirect_valid;
   logic [15:0] redirect_pc;
   logic        req   [2];
   logic [15:0] addr  [2];
   logic [15:0] rdata [2];
   logic        oval  [2];
   logic [15:0] oinstr[2];
   logic [15:0] opc   [2];
   logic [15:0] opcn  [2];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state
   logic [15:0] m_pc    [2];
   logic [15:0] m_q     [2][$];
   logic        m_valid [2];
   logic        m_known [2];
   logic [15:0] m_opc   [2];
   logic [15:0] m_instr [2];
   logic [15:0] m_pcn   [2];
   logic        m_init = 1'b0;

   always #5 clk = ~clk;

   pipeline_register_1_fetch #(.WIDTH(16), .RESET_PC(16'h0000)) dut0 (
      .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .imem_req(req[0]), .imem_addr(addr[0]),
      .imem_rdata(rdata[0]), .out_valid(oval[0]), .out_instruction(oinstr[0]),
      .out_pc(opc[0]), .out_pc_next(opcn[0])
   );

   pipeline_register_1_fetch #(.WIDTH(16), .RESET_PC(16'hFFFE)) dut1 (
      .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .imem_req(req[1]), .imem_addr(addr[1]),
      .imem_rdata(rdata[1]), .out_valid(oval[1]), .out_instruction(oinstr[1]),
      .out_pc(opc[1]), .out_pc_next(opcn[1])
   );

   // Synchronous instruction memory, contents 0xA000 + address
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++)
         if (req[k]) rdata[k] <= 16'hA000 + addr[k];
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic s, input logic rv, input logic [15:0] rp);
      logic [15:0] a;
      @(negedge clk);
      reset = r; stall = s; redirect_valid = rv; redirect_pc = rp;
      #1;
      if (m_init) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("imem_req[%0d]", k), {15'b0, req[k]}, {15'b0, !r && !s && !rv});
            chk($sformatf("imem_addr[%0d]", k), addr[k], m_pc[k]);
         end
      end
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (r) begin
            m_pc[k] = RPC[k]; m_q[k].delete(); m_valid[k] = 1'b0; m_known[k] = 1'b1;
            m_opc[k] = '0; m_instr[k] = '0; m_pcn[k] = '0;
         end else if (rv) begin
            m_pc[k] = rp; m_q[k].delete(); m_valid[k] = 1'b0;
         end else if (!s) begin
            if (m_q[k].size() > 0) begin
               a = m_q[k].pop_front();
               m_valid[k] = 1'b1; m_known[k] = 1'b1;
               m_opc[k] = a; m_instr[k] = 16'hA000 + a; m_pcn[k] = a + 16'd1;
            end else begin
               m_valid[k] = 1'b0; m_known[k] = 1'b0;
            end
            m_q[k].push_back(m_pc[k]);
            m_pc[k] = m_pc[k] + 16'd1;
         end
      end
      if (r) m_init = 1'b1;
      #1;
      if (m_init) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("out_valid[%0d]", k), {15'b0, oval[k]}, {15'b0, m_valid[k]});
            if (m_known[k]) begin
               chk($sformatf("out_pc[%0d]", k), opc[k], m_opc[k]);
               chk($sformatf("out_instruction[%0d]", k), oinstr[k], m_instr[k]);
               chk($sformatf("out_pc_next[%0d]", k), opcn[k], m_pcn[k]);
            end
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      step(1'b1, 1'b0, 1'b0, 16'h0);
      step(1'b1, 1'b0, 1'b0, 16'h0);

      // Reset then run; dut1 wraps through 0xFFFF
      run(2);
      chk("t1_valid", {15'b0, oval[0]}, 16'h0001);
      chk("t1_pc", opc[0], 16'h0000);
      chk("t1_instr", oinstr[0], 16'hA000);
      chk("t5_pc0", opc[1], 16'hFFFE);
      chk("t5_pcn0", opcn[1], 16'hFFFF);
      run(1);
      chk("t5_pc1", opc[1], 16'hFFFF);
      chk("t5_pcn1", opcn[1], 16'h0000);
      run(1);
      chk("t5_pc2", opc[1], 16'h0000);
      chk("t5_pcn2", opcn[1], 16'h0001);
      run(2);
      chk("t2_pre", opc[0], 16'h0004);

      // Stall three cycles at out_pc 4
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 16'h0);
         chk("t2_frozen", opc[0], 16'h0004);
      end
      for (int i = 0; i < 3; i++) begin
         run(1);
         chk("t2_release", opc[0], 16'h0005 + 16'(i));
      end

      // Redirect at out_pc 9
      run(2);
      chk("t3_pre", opc[0], 16'h0009);
      step(1'b0, 1'b0, 1'b1, 16'h0040);
      chk("t3_bubble", {15'b0, oval[0]}, 16'h0000);
      run(2);
      chk("t3_target", opc[0], 16'h0040);
      chk("t3_target_v", {15'b0, oval[0]}, 16'h0001);

      // Redirect together with stall, stall held two more cycles
      step(1'b0, 1'b1, 1'b1, 16'h0100);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      run(2);
      chk("t4_target", opc[0], 16'h0100);
      chk("t4_target_v", {15'b0, oval[0]}, 16'h0001);

      // Reset while stalled with a held instruction
      run(2);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      step(1'b1, 1'b1, 1'b0, 16'h0);
      chk("t6_valid", {15'b0, oval[0]}, 16'h0000);
      chk("t6_pc", opc[0], 16'h0000);
      run(2);
      chk("t6_restart", opc[0], 16'h0000);
      chk("t6_restart_v", {15'b0, oval[0]}, 16'h0001);

      // Random mix of stalls, redirects and the occasional reset
      for (int i = 0; i < 400; i++) begin
         logic        r, s, rv;
         logic [15:0] rp;
         r  = ($urandom_range(0, 49) == 0);
         s  = ($urandom_range(0, 9) < 3);
         rv = ($urandom_range(0, 9) == 0);
         rp = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                          : 16'($urandom);
         step(r, s, rv, rp);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
